xb_frame_sorter: RTL and testbench



---
 rtl/xb_frame_sorter.sv | 172 +++++++++++++++++
 tb/tb_xb_frame_sorter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/xb_frame_sorter.sv
// Frame sorter between the host-write and host-read FIFOs: receives NUM_ELEMS packed
// elements, sorts them with an odd-even transposition network, then streams them back out.
module xb_frame_sorter #(
  parameter int BUS_W     = 32,
  parameter int ELEM_W    = 16,
  parameter int NUM_ELEMS = 64,
  parameter int CNT_W     = 16
) (
  input  logic             bus_clk,
  input  logic             srst,
  input  logic             enable,
  input  logic             descending,
  output logic             recv_en,
  input  logic [BUS_W-1:0] recv_data,
  input  logic             recv_valid,
  output logic             send_en,
  output logic [BUS_W-1:0] send_data,
  input  logic             send_full,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_count
);

  localparam int PACK   = BUS_W / ELEM_W;
  localparam int WORDS  = NUM_ELEMS / PACK;
  localparam int WC_W   = $clog2(WORDS + 1);
  localparam int PASS_W = $clog2(NUM_ELEMS);
  localparam int IDX_W  = $clog2(NUM_ELEMS);
  localparam logic [WC_W-1:0]   WORDS_C   = WC_W'(WORDS);
  localparam logic [WC_W-1:0]   LAST_WORD = WC_W'(WORDS - 1);
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NUM_ELEMS - 1);

  typedef enum logic [4:0] {
    IDLE = 5'b00001,
    RECV = 5'b00010,
    EXEC = 5'b00100,
    SEND = 5'b01000,
    DONE = 5'b10000
  } state_t;

  state_t             state_q, state_d;
  logic [WC_W-1:0]    req_cnt_q, req_cnt_d;
  logic [WC_W-1:0]    rcv_cnt_q, rcv_cnt_d;
  logic [WC_W-1:0]    snd_cnt_q, snd_cnt_d;
  logic [PASS_W-1:0]  pass_q, pass_d;
  logic               desc_q, desc_d;
  logic [CNT_W-1:0]   frame_count_q, frame_count_d;
  logic [ELEM_W-1:0]  mem_q [NUM_ELEMS];
  logic [ELEM_W-1:0]  mem_d [NUM_ELEMS];
  logic [ELEM_W-1:0]  exec_val [NUM_ELEMS];
  logic [NUM_ELEMS-2:0] swap;
  logic [IDX_W-1:0]   rcv_base, snd_base;
  logic               send_act;

  assign rcv_base = IDX_W'(int'(rcv_cnt_q) * PACK);
  assign snd_base = IDX_W'(int'(snd_cnt_q) * PACK);
  assign send_act = (state_q == SEND) && (snd_cnt_q < WORDS_C);

  assign busy        = (state_q != IDLE);
  assign recv_en     = (state_q == RECV) && (req_cnt_q < WORDS_C);
  assign send_en     = send_act && !send_full;
  assign frame_done  = (state_q == DONE);
  assign frame_count = frame_count_q;

  // Pair (gi, gi+1) is active on passes whose parity matches gi; equal values stay put.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_ELEMS - 1; gi++) begin : g_cmp
      assign swap[gi] = (pass_q[0] == 1'(gi % 2)) &&
                        (desc_q ? (mem_q[gi] < mem_q[gi+1]) : (mem_q[gi] > mem_q[gi+1]));
    end
    for (gi = 0; gi < NUM_ELEMS; gi++) begin : g_exec
      if (gi == 0) begin : g_first
        assign exec_val[gi] = swap[0] ? mem_q[1] : mem_q[0];
      end else if (gi == NUM_ELEMS - 1) begin : g_last
        assign exec_val[gi] = swap[gi-1] ? mem_q[gi-1] : mem_q[gi];
      end else begin : g_mid
        assign exec_val[gi] = swap[gi]   ? mem_q[gi+1] :
                              swap[gi-1] ? mem_q[gi-1] : mem_q[gi];
      end
    end
    for (gi = 0; gi < PACK; gi++) begin : g_send
      assign send_data[gi*ELEM_W +: ELEM_W] = send_act ? mem_q[snd_base + IDX_W'(gi)] : '0;
    end
  endgenerate

  always_comb begin
    state_d       = state_q;
    req_cnt_d     = req_cnt_q;
    rcv_cnt_d     = rcv_cnt_q;
    snd_cnt_d     = snd_cnt_q;
    pass_d        = pass_q;
    desc_d        = desc_q;
    frame_count_d = frame_count_q;
    mem_d         = mem_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d   = RECV;
          desc_d    = descending;
          req_cnt_d = '0;
          rcv_cnt_d = '0;
        end
      end
      RECV: begin
        if (recv_en) req_cnt_d = req_cnt_q + 1'b1;
        if (recv_valid && (rcv_cnt_q < WORDS_C)) begin
          for (int k = 0; k < PACK; k++)
            mem_d[rcv_base + IDX_W'(k)] = recv_data[k*ELEM_W +: ELEM_W];
          rcv_cnt_d = rcv_cnt_q + 1'b1;
        end
        if (rcv_cnt_d == WORDS_C) begin
          state_d = EXEC;
          pass_d  = '0;
        end
      end
      EXEC: begin
        mem_d  = exec_val;
        pass_d = pass_q + 1'b1;
        if (pass_q == LAST_PASS) begin
          state_d   = SEND;
          pass_d    = '0;
          snd_cnt_d = '0;
        end
      end
      SEND: begin
        if (send_en) begin
          snd_cnt_d = snd_cnt_q + 1'b1;
          if (snd_cnt_q == LAST_WORD) state_d = DONE;
        end
      end
      DONE: begin
        state_d       = IDLE;
        frame_count_d = frame_count_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Session loss abandons the partial frame from any state.
    if (!enable) begin
      state_d   = IDLE;
      req_cnt_d = '0;
      rcv_cnt_d = '0;
      snd_cnt_d = '0;
      pass_d    = '0;
    end
  end

  always_ff @(posedge bus_clk) begin
    if (srst) begin
      state_q       <= IDLE;
      req_cnt_q     <= '0;
      rcv_cnt_q     <= '0;
      snd_cnt_q     <= '0;
      pass_q        <= '0;
      desc_q        <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      req_cnt_q     <= req_cnt_d;
      rcv_cnt_q     <= rcv_cnt_d;
      snd_cnt_q     <= snd_cnt_d;
      pass_q        <= pass_d;
      desc_q        <= desc_d;
      frame_count_q <= frame_count_d;
    end
  end

  always_ff @(posedge bus_clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_xb_frame_sorter.sv
// Directed bench for xb_frame_sorter with 8 elements per frame, modelling both FIFOs.
module tb_xb_frame_sorter;
  localparam int BUS_W = 32, ELEM_W = 16, NUM_ELEMS = 8, CNT_W = 16;

  logic bus_clk = 1'b0;
  logic srst = 1'b1, enable = 1'b0, descending = 1'b0;
  logic recv_en, send_en, busy, frame_done;
  logic recv_valid = 1'b0, send_full = 1'b0;
  logic [BUS_W-1:0] recv_data = '0;
  logic [BUS_W-1:0] send_data;
  logic [CNT_W-1:0] frame_count;

  xb_frame_sorter #(.BUS_W(BUS_W), .ELEM_W(ELEM_W), .NUM_ELEMS(NUM_ELEMS), .CNT_W(CNT_W)) dut (
    .bus_clk(bus_clk), .srst(srst), .enable(enable), .descending(descending),
    .recv_en(recv_en), .recv_data(recv_data), .recv_valid(recv_valid),
    .send_en(send_en), .send_data(send_data), .send_full(send_full),
    .busy(busy), .frame_done(frame_done), .frame_count(frame_count)
  );

  always #5 bus_clk = ~bus_clk;

  int checks = 0, passed = 0, fails = 0;
  logic [31:0] src_q[$], pend_q[$], out_q[$];
  int recv_en_total = 0, done_total = 0, stall_hits = 0, cyc = 0, stall_left = 0;
  bit gap_mode = 0, stall_mode = 0, stall_done = 0;

  // Sample DUT outputs mid-cycle.
  always @(negedge bus_clk) begin
    if (send_en) begin
      out_q.push_back(send_data);
      if (send_full) stall_hits++;
    end
    if (frame_done) done_total++;
    if (recv_en) begin
      recv_en_total++;
      if (src_q.size() > 0) pend_q.push_back(src_q.pop_front());
      else pend_q.push_back(32'hDEAD_BEEF);
    end
  end

  // Drive FIFO-side inputs just after the active edge.
  always @(posedge bus_clk) begin
    #1;
    cyc++;
    if (stall_left > 0) begin
      stall_left--;
      if (stall_left == 0) send_full = 1'b0;
    end else if (stall_mode && !stall_done && out_q.size() == 2) begin
      send_full  = 1'b1;
      stall_left = 10;
      stall_done = 1'b1;
    end
    if (pend_q.size() > 0 && (!gap_mode || (cyc % 3 == 0))) begin
      recv_valid = 1'b1;
      recv_data  = pend_q.pop_front();
    end else begin
      recv_valid = 1'b0;
      recv_data  = '0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_frame(input logic [31:0] w0, w1, w2, w3);
    src_q.push_back(w0); src_q.push_back(w1); src_q.push_back(w2); src_q.push_back(w3);
  endtask

  task automatic check_out(input string tag, input logic [31:0] e0, e1, e2, e3);
    logic [31:0] exp [4];
    logic [31:0] got;
    exp = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++) begin
      got = (out_q.size() > 0) ? out_q.pop_front() : 32'hxxxx_xxxx;
      check($sformatf("%s_w%0d", tag, i), {32'h0, got}, {32'h0, exp[i]});
    end
  endtask

  task automatic wait_done(input string tag, input int limit, output int n);
    n = 0;
    while (!frame_done && n < limit) begin
      @(negedge bus_clk);
      n++;
    end
    check({tag, "_timeout"}, 64'(n < limit), 64'd1);
  endtask

  int lat, rx0, dn0;

  initial begin
    repeat (3) @(negedge bus_clk);
    srst = 1'b0;
    @(negedge bus_clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_recv_en", 64'(recv_en), 64'd0);
    check("rst_send_en", 64'(send_en), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_frame_count", 64'(frame_count), 64'd0);
    check("rst_send_data", 64'(send_data), 64'd0);

    // Ascending, no stalls; minimum latency
    rx0 = recv_en_total; dn0 = done_total;
    load_frame(32'h0003_0007, 32'h0001_0008, 32'h0002_0006, 32'h0004_0005);
    enable = 1'b1;
    wait_done("t1", 100, lat);
    enable = 1'b0;
    check("t1_latency", 64'(lat), 64'd18);
    repeat (3) @(negedge bus_clk);
    check("t1_done_pulses", 64'(done_total - dn0), 64'd1);
    check("t1_recv_en_cycles", 64'(recv_en_total - rx0), 64'd4);
    check("t1_frame_count", 64'(frame_count), 64'd1);
    check("t1_out_count", 64'(out_q.size()), 64'd4);
    check_out("t1", 32'h0002_0001, 32'h0004_0003, 32'h0006_0005, 32'h0008_0007);

    // Descending
    load_frame(32'h0003_0007, 32'h0001_0008, 32'h0002_0006, 32'h0004_0005);
    descending = 1'b1;
    enable = 1'b1;
    wait_done("t2", 100, lat);
    enable = 1'b0;
    descending = 1'b0;
    repeat (3) @(negedge bus_clk);
    check("t2_frame_count", 64'(frame_count), 64'd2);
    check_out("t2", 32'h0007_0008, 32'h0005_0006, 32'h0003_0004, 32'h0001_0002);

    // Gapped recv_valid; descending flipped after latch must not matter
    rx0 = recv_en_total;
    gap_mode = 1'b1;
    load_frame(32'h0003_0007, 32'h0001_0008, 32'h0002_0006, 32'h0004_0005);
    enable = 1'b1;
    repeat (3) @(negedge bus_clk);
    descending = 1'b1;
    wait_done("t3", 200, lat);
    enable = 1'b0;
    descending = 1'b0;
    gap_mode = 1'b0;
    repeat (3) @(negedge bus_clk);
    check("t3_recv_en_cycles", 64'(recv_en_total - rx0), 64'd4);
    check("t3_frame_count", 64'(frame_count), 64'd3);
    check_out("t3", 32'h0002_0001, 32'h0004_0003, 32'h0006_0005, 32'h0008_0007);

    // send_full held 10 cycles after the second word
    stall_mode = 1'b1;
    load_frame(32'h0003_0007, 32'h0001_0008, 32'h0002_0006, 32'h0004_0005);
    enable = 1'b1;
    wait_done("t4", 200, lat);
    enable = 1'b0;
    stall_mode = 1'b0;
    check("t4_latency", 64'(lat), 64'd28);
    repeat (3) @(negedge bus_clk);
    check("t4_stall_applied", 64'(stall_done), 64'd1);
    check("t4_writes_while_full", 64'(stall_hits), 64'd0);
    check("t4_out_count", 64'(out_q.size()), 64'd4);
    check("t4_frame_count", 64'(frame_count), 64'd4);
    check_out("t4", 32'h0002_0001, 32'h0004_0003, 32'h0006_0005, 32'h0008_0007);

    // enable dropped mid-EXEC, then a clean frame of duplicates and extremes
    dn0 = done_total;
    load_frame(32'h0003_0007, 32'h0001_0008, 32'h0002_0006, 32'h0004_0005);
    enable = 1'b1;
    repeat (9) @(negedge bus_clk);
    check("t5_busy_in_exec", 64'(busy), 64'd1);
    enable = 1'b0;
    @(negedge bus_clk);
    check("t5_idle_after_drop", 64'(busy), 64'd0);
    repeat (20) @(negedge bus_clk);
    check("t5_no_writes", 64'(out_q.size()), 64'd0);
    check("t5_no_done", 64'(done_total - dn0), 64'd0);
    check("t5_frame_count", 64'(frame_count), 64'd4);
    load_frame(32'h0000_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_8000);
    enable = 1'b1;
    wait_done("t5b", 100, lat);
    enable = 1'b0;
    repeat (3) @(negedge bus_clk);
    check("t5b_frame_count", 64'(frame_count), 64'd5);
    check_out("t5b", 32'h0000_0000, 32'h8000_0000, 32'hFFFF_8000, 32'hFFFF_FFFF);

    // Reset, then two back-to-back frames
    srst = 1'b1;
    repeat (2) @(negedge bus_clk);
    srst = 1'b0;
    @(negedge bus_clk);
    check("t6_rst_frame_count", 64'(frame_count), 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    dn0 = done_total;
    load_frame(32'h0000_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_8000);
    load_frame(32'h0003_0007, 32'h0001_0008, 32'h0002_0006, 32'h0004_0005);
    enable = 1'b1;
    wait_done("t6a", 100, lat);
    @(negedge bus_clk);
    wait_done("t6b", 100, lat);
    enable = 1'b0;
    repeat (3) @(negedge bus_clk);
    check("t6_done_pulses", 64'(done_total - dn0), 64'd2);
    check("t6_frame_count", 64'(frame_count), 64'd2);
    check("t6_out_count", 64'(out_q.size()), 64'd8);
    check_out("t6a", 32'h0000_0000, 32'h8000_0000, 32'hFFFF_8000, 32'hFFFF_FFFF);
    check_out("t6b", 32'h0002_0001, 32'h0004_0003, 32'h0006_0005, 32'h0008_0007);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
